// File: rtl/pic_host_pkg.sv
// Shared types and defaults for the 8259-style host bus master.
// Holds the FSM state encoding, the phase-timer width and the default strobe/gap lengths.
package pic_host_pkg;

    localparam int unsigned CNT_W                 = 4;
    localparam int unsigned DEFAULT_STROBE_CYCLES = 2;
    localparam int unsigned DEFAULT_GAP_CYCLES    = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD_SETUP,
        CMD_STROBE,
        CMD_HOLD,
        ACK1,
        ACK_GAP,
        ACK2,
        ACK_DONE
    } state_t;

endpackage

// File: rtl/pic_cycle_timer.sv
// Loadable down-counter timing one strobe or gap phase.
// Loading N makes done assert on the Nth cycle after the load edge.
module pic_cycle_timer
    import pic_host_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  cnt_t load_value,
    output logic done
);

    cnt_t count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value - cnt_t'(1);
        end else if (count != '0) begin
            count <= count - cnt_t'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pic_host_bus_master.sv
// Host-side bus master for an 8259-style interrupt controller: register
// read/write cycles plus the two-pulse INTA acknowledge that fetches the vector.
module pic_host_bus_master
    import pic_host_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEFAULT_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,

    input  logic       inta_enable,
    input  logic       interrupt_to_cpu,
    output logic       vector_valid,
    output logic [7:0] vector,

    output logic       chip_select_n,
    output logic       read_enable_n,
    output logic       write_enable_n,
    output logic       interrupt_acknowledge_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_oe,
    input  logic [7:0] data_bus_in
);

    state_t     state;
    state_t     state_next;
    logic       int_req;
    logic       accept;
    logic       timer_load;
    cnt_t       timer_value;
    logic       timer_done;
    logic       write_q;
    logic       addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic [7:0] vector_q;

    pic_cycle_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Acknowledge has priority over a host command offered in the same cycle.
    assign int_req = interrupt_to_cpu && inta_enable;
    assign accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next              = state;
        timer_load              = 1'b0;
        timer_value             = cnt_t'(STROBE_CYCLES);
        cmd_ready               = 1'b0;
        chip_select_n           = 1'b1;
        read_enable_n           = 1'b1;
        write_enable_n          = 1'b1;
        interrupt_acknowledge_n = 1'b1;
        data_bus_oe             = 1'b0;
        rsp_valid               = 1'b0;
        vector_valid            = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = !int_req && !reset;
                if (int_req) begin
                    state_next = ACK1;
                    timer_load = 1'b1;
                end else if (cmd_valid && !reset) begin
                    state_next = CMD_SETUP;
                end
            end
            CMD_SETUP: begin
                chip_select_n = 1'b0;
                data_bus_oe   = write_q;
                state_next    = CMD_STROBE;
                timer_load    = 1'b1;
            end
            CMD_STROBE: begin
                chip_select_n  = 1'b0;
                data_bus_oe    = write_q;
                write_enable_n = !write_q;
                read_enable_n  = write_q;
                if (timer_done) begin
                    state_next = CMD_HOLD;
                end
            end
            CMD_HOLD: begin
                chip_select_n = 1'b0;
                data_bus_oe   = write_q;
                rsp_valid     = 1'b1;
                state_next    = IDLE;
            end
            ACK1: begin
                interrupt_acknowledge_n = 1'b0;
                if (timer_done) begin
                    state_next  = ACK_GAP;
                    timer_load  = 1'b1;
                    timer_value = cnt_t'(GAP_CYCLES);
                end
            end
            ACK_GAP: begin
                if (timer_done) begin
                    state_next = ACK2;
                    timer_load = 1'b1;
                end
            end
            ACK2: begin
                interrupt_acknowledge_n = 1'b0;
                if (timer_done) begin
                    state_next = ACK_DONE;
                end
            end
            ACK_DONE: begin
                vector_valid = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command fields are frozen at accept so the bus stays stable for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            addr_q   <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            vector_q <= '0;
        end else begin
            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_a0;
                wdata_q <= cmd_wdata;
            end
            if (state == CMD_STROBE && timer_done) begin
                rdata_q <= write_q ? 8'h00 : data_bus_in;
            end
            if (state == ACK2 && timer_done) begin
                vector_q <= data_bus_in;
            end
        end
    end

    assign address      = addr_q;
    assign data_bus_out = wdata_q;
    assign rsp_rdata    = rdata_q;
    assign vector       = vector_q;

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Self-checking bench: a register-file/INTA device model on the bus, a scoreboard
// of expected responses and vectors, and a protocol monitor for strobe timing.
module tb_pic_host_bus_master;

    localparam int STROBE = 2;
    localparam int GAP    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_a0;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       inta_enable;
    logic       interrupt_to_cpu;
    logic       vector_valid;
    logic [7:0] vector;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic       interrupt_acknowledge_n;
    logic       address;
    logic [7:0] data_bus_out;
    logic       data_bus_oe;
    logic [7:0] data_bus_in;

    always #5 clk = ~clk;

    pic_host_bus_master #(
        .STROBE_CYCLES (STROBE),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_write               (cmd_write),
        .cmd_a0                  (cmd_a0),
        .cmd_wdata               (cmd_wdata),
        .rsp_valid               (rsp_valid),
        .rsp_rdata               (rsp_rdata),
        .inta_enable             (inta_enable),
        .interrupt_to_cpu        (interrupt_to_cpu),
        .vector_valid            (vector_valid),
        .vector                  (vector),
        .chip_select_n           (chip_select_n),
        .read_enable_n           (read_enable_n),
        .write_enable_n          (write_enable_n),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .address                 (address),
        .data_bus_out            (data_bus_out),
        .data_bus_oe             (data_bus_oe),
        .data_bus_in             (data_bus_in)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- device model on the bus ----------------
    logic [7:0] dev_regs [2] = '{8'h00, 8'h00};
    logic [7:0] dev_vec  = 8'h00;
    logic [7:0] noise    = 8'h00;
    int         dev_falls = 0;

    always @(negedge clk) begin
        noise <= 8'($urandom);
        if (!reset && !chip_select_n && !write_enable_n) dev_regs[address] <= data_bus_out;
    end

    always @(negedge interrupt_acknowledge_n or posedge reset) begin
        if (reset) dev_falls <= 0;
        else       dev_falls <= dev_falls + 1;
    end

    // First INTA pulse returns the CALL opcode, second returns the vector.
    always_comb begin
        data_bus_in = noise;
        if (!interrupt_acknowledge_n) data_bus_in = dev_falls[0] ? 8'hCD : dev_vec;
        else if (!read_enable_n)      data_bus_in = dev_regs[address];
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic       is_vec;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       sb_e;
    logic [7:0] model_regs [2] = '{8'h00, 8'h00};

    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                check("rsp_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("rsp_kind", 32'(sb_e.is_vec), 0);
                    check("rsp_rdata", 32'(rsp_rdata), 32'(sb_e.data));
                end
            end
            if (vector_valid) begin
                check("vec_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    check("vec_kind", 32'(sb_e.is_vec), 1);
                    check("vector", 32'(vector), 32'(sb_e.data));
                end
            end
        end
    end

    // ---------------- bus protocol monitor ----------------
    int wr_run = 0, rd_run = 0, cs_run = 0, inta_run = 0, gap_run = 0;
    bit inta_second = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            wr_run = 0; rd_run = 0; cs_run = 0; inta_run = 0; gap_run = 0;
            inta_second = 1'b0;
        end else begin
            if (!write_enable_n) begin
                wr_run++;
                check("wr_oe", 32'(data_bus_oe), 1);
            end else if (wr_run != 0) begin
                check("wr_width", wr_run, STROBE);
                wr_run = 0;
            end
            if (!read_enable_n) begin
                rd_run++;
                check("rd_oe", 32'(data_bus_oe), 0);
            end else if (rd_run != 0) begin
                check("rd_width", rd_run, STROBE);
                rd_run = 0;
            end
            if (!chip_select_n) begin
                cs_run++;
                check("cs_cmd_ready", 32'(cmd_ready), 0);
                check("cs_no_inta", 32'(interrupt_acknowledge_n), 1);
            end else if (cs_run != 0) begin
                check("cs_width", cs_run, STROBE + 2);
                cs_run = 0;
            end
            if (!interrupt_acknowledge_n) begin
                if (inta_run == 0 && inta_second) check("inta_gap", gap_run, GAP);
                inta_run++;
                check("inta_cs_high", 32'(chip_select_n), 1);
                check("inta_oe_low", 32'(data_bus_oe), 0);
                check("inta_cmd_ready", 32'(cmd_ready), 0);
            end else if (inta_run != 0) begin
                check("inta_width", inta_run, STROBE);
                inta_run    = 0;
                inta_second = !inta_second;
                gap_run     = 1;
            end else if (inta_second) begin
                gap_run++;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_cmd(input logic wr, input logic a0, input logic [7:0] wd);
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_a0 = a0; cmd_wdata = wd;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        check("cmd_accept_in_time", 32'(got), 1);
        if (got) begin
            @(posedge clk);
            e.is_vec = 1'b0;
            e.data   = wr ? 8'h00 : model_regs[a0];
            sb_q.push_back(e);
            if (wr) model_regs[a0] = wd;
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_int(input logic [7:0] vec, input int drop_delay, input bit drop_enable);
        bit   seen;
        exp_t e;
        @(posedge clk); #1;
        dev_vec = vec;
        e.is_vec = 1'b1;
        e.data   = vec;
        sb_q.push_back(e);
        interrupt_to_cpu = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!interrupt_acknowledge_n) begin seen = 1'b1; break; end
        end
        check("inta_start_in_time", 32'(seen), 1);
        if (seen) repeat (drop_delay) @(posedge clk);
        #1;
        interrupt_to_cpu = 1'b0;
        if (drop_enable) inta_enable = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (vector_valid) begin seen = 1'b1; break; end
        end
        check("vector_in_time", 32'(seen), 1);
        inta_enable = 1'b1;
    endtask

    task automatic wait_negedge_cond_wr_low();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!write_enable_n) begin seen = 1'b1; break; end
        end
        check("wr_strobe_seen", 32'(seen), 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_wdata = 8'h00;
        inta_enable = 1'b1; interrupt_to_cpu = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(chip_select_n), 1);
        check("rst_rd_n", 32'(read_enable_n), 1);
        check("rst_wr_n", 32'(write_enable_n), 1);
        check("rst_inta_n", 32'(interrupt_acknowledge_n), 1);
        check("rst_oe", 32'(data_bus_oe), 0);
        check("rst_address", 32'(address), 0);
        check("rst_data_out", 32'(data_bus_out), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_vector_valid", 32'(vector_valid), 0);
        check("rst_vector", 32'(vector), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        // Directed: write, write+read back, plain acknowledge, INT dropped in the gap.
        do_cmd(1'b1, 1'b0, 8'h13);
        do_cmd(1'b1, 1'b1, 8'hFB);
        do_cmd(1'b0, 1'b1, 8'h00);
        do_int(8'h08, 1, 1'b0);
        do_int(8'hA7, 2, 1'b0);
        do_int(8'h3C, 3, 1'b1);

        // Command and INT raised in the same IDLE cycle: acknowledge goes first.
        fork
            do_int(8'h5C, 1, 1'b0);
            do_cmd(1'b0, 1'b0, 8'h00);
            begin
                @(posedge clk);
                @(negedge clk);
                check("simul_cmd_ready", 32'(cmd_ready), 0);
            end
        join

        // Reset in the middle of a write strobe aborts the access.
        do_cmd(1'b1, 1'b0, 8'h6E);
        wait_negedge_cond_wr_low();
        @(posedge clk); #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("abort_cs_n", 32'(chip_select_n), 1);
        check("abort_wr_n", 32'(write_enable_n), 1);
        check("abort_rd_n", 32'(read_enable_n), 1);
        check("abort_oe", 32'(data_bus_oe), 0);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 0);
        check("abort_rsp_rdata", 32'(rsp_rdata), 0);
        check("abort_data_out", 32'(data_bus_out), 0);
        @(posedge clk); #1 reset = 1'b0;
        do_cmd(1'b1, 1'b0, 8'h31);
        do_cmd(1'b0, 1'b0, 8'h00);

        // Randomised mix of accesses and acknowledges.
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                do_cmd(1'($urandom), 1'($urandom), 8'($urandom));
            end else if (op <= 7) begin
                do_int(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
            end else if (op == 8) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end else begin
                @(posedge clk); #1;
                interrupt_to_cpu = 1'b1;
                inta_enable      = 1'b0;
                do_cmd(1'($urandom), 1'($urandom), 8'($urandom));
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("disabled_no_inta", 32'(interrupt_acknowledge_n), 1);
                end
                @(posedge clk); #1;
                interrupt_to_cpu = 1'b0;
                inta_enable      = 1'b1;
            end
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
